// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: default widths, reset PC, memory depth,
// the bubble encoding and the PC-update operation type.
package cpu_pkg;

  localparam int unsigned     XLEN_DEF       = 32;
  localparam logic [31:0]     RESET_PC_DEF   = 32'h0;
  localparam int unsigned     IMEM_DEPTH_DEF = 256;
  localparam logic [31:0]     BUBBLE_INSTR   = 32'h0;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_op_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: hold, load a target, or advance by one word.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  pc_op_e          pc_op_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // NOTE: the default assignment ahead of the case keeps this block a pure
  // mux; leaving any path unassigned would infer a latch.
  always_comb begin
    pc_d = pc_q;
    unique case (pc_op_i)
      PC_INC:  pc_d = pc_q + XLEN'(4);
      PC_LOAD: pc_d = load_pc_i;
      default: pc_d = pc_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, stall/redirect/halt handling.
// Optional stall/flush performance counters when IF_STAGE_PERF_CNT_EN is defined.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int unsigned      IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned      CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam longint unsigned FETCH_LIMIT = longint'(IMEM_DEPTH) * 4;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_target;
  logic            halted;
  pc_op_e          pc_op;
  ifid_op_e        ifid_op;

  logic [XLEN-1:0] if_id_pc_q,    if_id_pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;

  // Targets are forced to word alignment; the low bits are intentionally dropped.
  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign halted = (64'(pc) >= FETCH_LIMIT);

  // Priority: idle, redirect (beats stall), stall, halted, normal fetch.
  always_comb begin
    pc_op   = PC_INC;
    ifid_op = IFID_LOAD;
    if (!start_i) begin
      pc_op   = PC_HOLD;
      ifid_op = IFID_BUBBLE;
    end else if (redirect_i) begin
      pc_op   = PC_LOAD;
      ifid_op = IFID_BUBBLE;
    end else if (stall_i) begin
      pc_op   = PC_HOLD;
      ifid_op = IFID_HOLD;
    end else if (halted) begin
      pc_op   = PC_HOLD;
      ifid_op = IFID_BUBBLE;
    end
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .pc_op_i   (pc_op),
    .load_pc_i (redirect_target),
    .pc_o      (pc)
  );

  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    unique case (ifid_op)
      IFID_BUBBLE: begin
        if_id_pc_d    = '0;
        if_id_instr_d = BUBBLE_INSTR;
        if_id_valid_d = 1'b0;
      end
      IFID_LOAD: begin
        if_id_pc_d    = pc;
        if_id_instr_d = imem_instr_i;
        if_id_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every pipeline flop is cleared by the async reset so a bubble is
  // presented immediately, without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= BUBBLE_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             stall_evt;
  logic             flush_evt;

  assign stall_evt = start_i && stall_i && !redirect_i;
  assign flush_evt = start_i && redirect_i;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign pc_o          = pc;
  assign imem_addr_o   = pc;
  assign halted_o      = halted;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, end-of-memory halt,
// idle and asynchronous reset, with hand-computed expectations.
module tb_if_stage;

`ifdef IF_STAGE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .pc_o          (pc_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_valid_o (if_id_valid_o),
    .halted_o      (halted_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: a known ADDI at 0, otherwise an address-tagged word.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return 32'h00000013 | (a << 12);
  endfunction

  always_comb imem_instr_i = (imem_addr_o < 32'd1024) ? instr_at(imem_addr_o) : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_ifid_pc"},    if_id_pc_o,    32'h0);
    check({tag, "_ifid_instr"}, if_id_instr_o, 32'h0);
    check({tag, "_ifid_valid"}, 32'(if_id_valid_o), 32'h0);
  endtask

  initial begin
    rst_n_i       = 1'b0;
    start_i       = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    #12;
    check("rst_pc",      pc_o,          32'h0);
    check("rst_addr",    imem_addr_o,   32'h0);
    check_bubble("rst");
    check("rst_halted",  32'(halted_o), 32'h0);
    check("rst_stall_cnt", stall_cnt_o, 32'h0);
    check("rst_flush_cnt", flush_cnt_o, 32'h0);
    rst_n_i = 1'b1;
    #2;

    // First fetch: one-cycle latency into IF/ID.
    start_i = 1'b1;
    tick();
    check("f0_ifid_pc",    if_id_pc_o,    32'h0);
    check("f0_ifid_instr", if_id_instr_o, 32'h00500093);
    check("f0_ifid_valid", 32'(if_id_valid_o), 32'h1);
    check("f0_pc",         pc_o,          32'h4);
    tick();
    check("f1_pc",         pc_o,          32'h8);
    check("f1_ifid_instr", if_id_instr_o, instr_at(32'h4));

    // Two stall cycles at pc 8: everything holds.
    stall_i = 1'b1;
    tick();
    tick();
    check("st_pc",         pc_o,          32'h8);
    check("st_ifid_pc",    if_id_pc_o,    32'h4);
    check("st_ifid_instr", if_id_instr_o, instr_at(32'h4));
    check("st_ifid_valid", 32'(if_id_valid_o), 32'h1);
    check("st_stall_cnt",  stall_cnt_o,   32'(2 * PERF));

    // Redirect with a simultaneous stall: redirect wins, target word-aligned.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h2E;
    tick();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    check("rd_pc", pc_o, 32'h2C);
    check_bubble("rd");
    check("rd_flush_cnt", flush_cnt_o, 32'(PERF));
    check("rd_stall_cnt", stall_cnt_o, 32'(2 * PERF));
    tick();
    check("rd1_ifid_pc",    if_id_pc_o,    32'h2C);
    check("rd1_ifid_instr", if_id_instr_o, instr_at(32'h2C));
    check("rd1_pc",         pc_o,          32'h30);

    // Idle for three cycles.
    start_i = 1'b0;
    tick();
    tick();
    tick();
    check("idle_pc",        pc_o, 32'h30);
    check_bubble("idle");
    check("idle_stall_cnt", stall_cnt_o, 32'(2 * PERF));
    check("idle_flush_cnt", flush_cnt_o, 32'(PERF));
    start_i = 1'b1;

    // Run sequentially to the last word of memory.
    for (int n = 0; n < 400 && pc_o != 32'd1020; n++) tick();
    check("end_pc",      pc_o,          32'd1020);
    check("end_halted",  32'(halted_o), 32'h0);
    check("end_ifid_pc", if_id_pc_o,    32'd1016);
    tick();
    check("h0_pc",         pc_o,          32'd1024);
    check("h0_halted",     32'(halted_o), 32'h1);
    check("h0_ifid_pc",    if_id_pc_o,    32'd1020);
    check("h0_ifid_instr", if_id_instr_o, instr_at(32'd1020));
    tick();
    tick();
    check("h1_pc",     pc_o,          32'd1024);
    check("h1_halted", 32'(halted_o), 32'h1);
    check_bubble("h1");

    // Redirect back into range resumes fetch.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h10;
    tick();
    redirect_i = 1'b0;
    check("hr_pc",        pc_o,          32'h10);
    check("hr_halted",    32'(halted_o), 32'h0);
    check("hr_flush_cnt", flush_cnt_o,   32'(2 * PERF));
    check_bubble("hr");
    tick();
    check("hr1_ifid_pc",    if_id_pc_o,    32'h10);
    check("hr1_ifid_instr", if_id_instr_o, instr_at(32'h10));
    check("hr1_ifid_valid", 32'(if_id_valid_o), 32'h1);
    check("hr1_pc",         pc_o,          32'h14);

    // Reset pulsed between edges during a stall.
    stall_i = 1'b1;
    tick();
    check("ar_pre_pc",        pc_o,        32'h14);
    check("ar_pre_stall_cnt", stall_cnt_o, 32'(3 * PERF));
    #2;
    rst_n_i = 1'b0;
    #1;
    check("ar_pc",        pc_o,        32'h0);
    check_bubble("ar");
    check("ar_stall_cnt", stall_cnt_o, 32'h0);
    check("ar_flush_cnt", flush_cnt_o, 32'h0);
    #1;
    rst_n_i = 1'b1;
    stall_i = 1'b0;
    tick();
    check("ar_resume_ifid_instr", if_id_instr_o, 32'h00500093);
    check("ar_resume_pc",         pc_o,          32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
